// File: rtl/ct_cp0_lpmd_seq_pkg.sv
// Shared cp0 low-power-mode encodings: sequencer states, mode values and drain limit.
package ct_cp0_lpmd_seq_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_DRAIN = 3'd1,
      SEQ_SLEEP = 3'd2,
      SEQ_WAKE  = 3'd3,
      SEQ_DONE  = 3'd4
   } seq_state_e;

   localparam logic [1:0]  LPMD_MODE_ILLEGAL = 2'b11;
   localparam logic [1:0]  LPMD_B_RUN        = 2'b11;
   localparam int unsigned CP0_DRAIN_TO      = 255;

endpackage

// File: rtl/ct_cp0_lpmd_seq_gated_clk_cell.sv
// Latch-based clock gate: the enable is captured while the clock is low so the gated clock never glitches.
module ct_cp0_lpmd_seq_gated_clk_cell (
   input  logic clk_i,
   input  logic en_i,
   output logic clk_o
);

   logic en_lat;

   always_latch begin
      if (!clk_i) en_lat <= en_i;
   end

   assign clk_o = clk_i & en_lat;

endmodule

// File: rtl/ct_cp0_lpmd_seq.sv
// Low-power-mode entry/exit sequencer: drains the pipeline, gates the core clock, and
// restores it after a configurable stabilisation delay once a wake source arrives.
module ct_cp0_lpmd_seq
   import ct_cp0_lpmd_seq_pkg::*;
#(
   parameter int unsigned DRAIN_TO = CP0_DRAIN_TO,
   parameter int unsigned WDLY_W   = 4
) (
   input  logic              forever_cpuclk,
   input  logic              cpurst,
   input  logic              lpmd_req,
   input  logic [1:0]        lpmd_mode,
   input  logic              rtu_yy_xx_flush,
   input  logic              ifu_yy_xx_no_op,
   input  logic              lsu_yy_xx_no_op,
   input  logic              mmu_yy_xx_no_op,
   input  logic              biu_yy_xx_no_op,
   input  logic              int_wake,
   input  logic              dbg_wake,
   input  logic [WDLY_W-1:0] wake_dly_cfg,
   output logic              cp0_xx_no_op_req,
   output logic [1:0]        lpmd_b,
   output logic              cp0_yy_clk_en,
   output logic              lpmd_cmplt,
   output logic              lpmd_abort,
   output logic [2:0]        seq_state
);

   localparam logic [7:0] DRAIN_LIMIT = 8'(DRAIN_TO);

   seq_state_e        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [7:0]        drain_cnt_q, drain_cnt_d;
   logic [WDLY_W-1:0] wake_cnt_q, wake_cnt_d;
   logic [1:0]        lpmd_b_q, lpmd_b_d;
   logic              no_op_req_q, clk_en_q, cmplt_q, abort_q, abort_d;
   logic              all_ack, any_wake, cnt_en, cnt_clk;

   assign all_ack  = ifu_yy_xx_no_op & lsu_yy_xx_no_op & mmu_yy_xx_no_op & biu_yy_xx_no_op;
   assign any_wake = int_wake | dbg_wake;
   assign cnt_en   = (state_q != SEQ_IDLE) | lpmd_req;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      abort_d = 1'b0;
      case (state_q)
         SEQ_IDLE: begin
            if (lpmd_req) begin
               if (lpmd_mode == LPMD_MODE_ILLEGAL) begin
                  state_d = SEQ_DONE;
               end else begin
                  state_d = SEQ_DRAIN;
                  mode_d  = lpmd_mode;
               end
            end
         end
         // Flush beats wake beats acks beats timeout.
         SEQ_DRAIN: begin
            if (rtu_yy_xx_flush) begin
               state_d = SEQ_IDLE;
            end else if (any_wake) begin
               state_d = SEQ_DONE;
            end else if (all_ack) begin
               state_d = SEQ_SLEEP;
            end else if (drain_cnt_q == DRAIN_LIMIT) begin
               state_d = SEQ_IDLE;
               abort_d = 1'b1;
            end
         end
         SEQ_SLEEP: begin
            if (dbg_wake) state_d = SEQ_DONE;
            else if (int_wake) state_d = SEQ_WAKE;
         end
         SEQ_WAKE: begin
            if (dbg_wake || (wake_cnt_q == '0)) state_d = SEQ_DONE;
         end
         SEQ_DONE: state_d = SEQ_IDLE;
         default:  state_d = SEQ_IDLE;
      endcase

      lpmd_b_d = (state_d == SEQ_SLEEP) ? ~mode_q : LPMD_B_RUN;

      drain_cnt_d = '0;
      if ((state_q == SEQ_DRAIN) && (state_d == SEQ_DRAIN)) drain_cnt_d = drain_cnt_q + 8'd1;

      // The wake delay loads on entry and counts down to zero while held in WAKE.
      wake_cnt_d = '0;
      if (state_d == SEQ_WAKE) wake_cnt_d = (state_q == SEQ_WAKE) ? wake_cnt_q - 1'b1 : wake_dly_cfg;
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q     <= SEQ_IDLE;
         mode_q      <= 2'b00;
         lpmd_b_q    <= LPMD_B_RUN;
         clk_en_q    <= 1'b1;
         no_op_req_q <= 1'b0;
         cmplt_q     <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         lpmd_b_q    <= lpmd_b_d;
         clk_en_q    <= &lpmd_b_d;
         no_op_req_q <= (state_d == SEQ_DRAIN);
         cmplt_q     <= (state_d == SEQ_DONE);
         abort_q     <= abort_d;
      end
   end

   ct_cp0_lpmd_seq_gated_clk_cell x_gated_clk_cell (
      .clk_i (forever_cpuclk),
      .en_i  (cnt_en),
      .clk_o (cnt_clk)
   );

   always_ff @(posedge cnt_clk or posedge cpurst) begin
      if (cpurst) begin
         drain_cnt_q <= '0;
         wake_cnt_q  <= '0;
      end else begin
         drain_cnt_q <= drain_cnt_d;
         wake_cnt_q  <= wake_cnt_d;
      end
   end

   assign cp0_xx_no_op_req = no_op_req_q;
   assign lpmd_b           = lpmd_b_q;
   assign cp0_yy_clk_en    = clk_en_q;
   assign lpmd_cmplt       = cmplt_q;
   assign lpmd_abort       = abort_q;
   assign seq_state        = state_q;

endmodule

// File: tb/tb_ct_cp0_lpmd_seq.sv
// Directed bench for the low-power-mode sequencer: per-cycle vector table plus drain-timeout and reset sequences.
module tb_ct_cp0_lpmd_seq;

   localparam int WDLY_W = 4;
   localparam logic [2:0] S_I = 3'd0, S_DR = 3'd1, S_SL = 3'd2, S_WK = 3'd3, S_DN = 3'd4;
   localparam logic [3:0] AK = 4'hF;

   logic              clk, rst;
   logic              lpmd_req;
   logic [1:0]        lpmd_mode;
   logic              rtu_yy_xx_flush;
   logic              ifu_no_op, lsu_no_op, mmu_no_op, biu_no_op;
   logic              int_wake, dbg_wake;
   logic [WDLY_W-1:0] wake_dly_cfg;
   logic              cp0_xx_no_op_req;
   logic [1:0]        lpmd_b;
   logic              cp0_yy_clk_en;
   logic              lpmd_cmplt;
   logic              lpmd_abort;
   logic [2:0]        seq_state;

   ct_cp0_lpmd_seq #(.DRAIN_TO(255), .WDLY_W(WDLY_W)) dut (
      .forever_cpuclk   (clk),
      .cpurst           (rst),
      .lpmd_req         (lpmd_req),
      .lpmd_mode        (lpmd_mode),
      .rtu_yy_xx_flush  (rtu_yy_xx_flush),
      .ifu_yy_xx_no_op  (ifu_no_op),
      .lsu_yy_xx_no_op  (lsu_no_op),
      .mmu_yy_xx_no_op  (mmu_no_op),
      .biu_yy_xx_no_op  (biu_no_op),
      .int_wake         (int_wake),
      .dbg_wake         (dbg_wake),
      .wake_dly_cfg     (wake_dly_cfg),
      .cp0_xx_no_op_req (cp0_xx_no_op_req),
      .lpmd_b           (lpmd_b),
      .cp0_yy_clk_en    (cp0_yy_clk_en),
      .lpmd_cmplt       (lpmd_cmplt),
      .lpmd_abort       (lpmd_abort),
      .seq_state        (seq_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       req;
      logic [1:0] mode;
      logic       flush;
      logic [3:0] ack;
      logic       iw;
      logic       dw;
      logic [3:0] cfg;
      logic [2:0] st;
      logic       nop;
      logic [1:0] lb;
      logic       ce;
      logic       ce_chk;
      logic       cm;
      logic       ab;
   } vec_t;

   vec_t       vecs[$];
   logic [8:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic req, input logic [1:0] mode, input logic flush, input logic [3:0] ack,
                        input logic iw, input logic dw, input logic [3:0] cfg);
      lpmd_req        = req;
      lpmd_mode       = mode;
      rtu_yy_xx_flush = flush;
      {ifu_no_op, lsu_no_op, mmu_no_op, biu_no_op} = ack;
      int_wake        = iw;
      dbg_wake        = dw;
      wake_dly_cfg    = cfg;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic req, input logic [1:0] mode, input logic flush, input logic [3:0] ack,
                               input logic iw, input logic dw, input logic [3:0] cfg,
                               input logic [2:0] st, input logic nop, input logic [1:0] lb,
                               input logic ce, input logic ce_chk, input logic cm, input logic ab);
      vec_t v;
      v.req = req; v.mode = mode; v.flush = flush; v.ack = ack; v.iw = iw; v.dw = dw; v.cfg = cfg;
      v.st = st; v.nop = nop; v.lb = lb; v.ce = ce; v.ce_chk = ce_chk; v.cm = cm; v.ab = ab;
      vecs.push_back(v);
   endfunction

   // Drives a request with no acks and stops after the edge where the counter reaches 255.
   task automatic drain_255(input string tag, input logic [1:0] mode);
      logic lb_moved, early_exit;
      lb_moved   = 1'b0;
      early_exit = 1'b0;
      @(negedge clk);
      drive(1'b1, mode, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0);
      step();
      check({tag, "_enter"}, {13'd0, seq_state}, {13'd0, S_DR});
      @(negedge clk);
      drive(1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0);
      for (int k = 1; k <= 255; k++) begin
         step();
         if (lpmd_b !== 2'b11) lb_moved = 1'b1;
         if (lpmd_abort !== 1'b0 || seq_state !== S_DR) early_exit = 1'b1;
         @(negedge clk);
      end
      check({tag, "_lb_steady"}, {15'd0, lb_moved}, 16'd0);
      check({tag, "_no_early_exit"}, {15'd0, early_exit}, 16'd0);
   endtask

   initial begin
      logic [8:0] act;
      logic       cm_seen;

      rst = 1'b1;
      drive(1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_state",   {13'd0, seq_state}, {13'd0, S_I});
      check("rst_lpmd_b",  {14'd0, lpmd_b}, 16'h3);
      check("rst_clk_en",  {15'd0, cp0_yy_clk_en}, 16'h1);
      check("rst_pulses",  {13'd0, cp0_xx_no_op_req, lpmd_cmplt, lpmd_abort}, 16'h0);
      @(negedge clk);
      rst = 1'b0;

      // mode 00, acks at +3, int_wake at +10, wake delay 2 (clk_en not judged while asleep in mode 00)
      add(1, 2'b00, 0, 0,  0, 0, 4'd2, S_DR, 1, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd2, S_DR, 1, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd2, S_DR, 1, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, AK, 0, 0, 4'd2, S_SL, 0, 2'b11, 1, 0, 0, 0);
      for (int k = 4; k <= 9; k++) add(0, 2'b00, 0, 0, 0, 0, 4'd2, S_SL, 0, 2'b11, 1, 0, 0, 0);
      add(0, 2'b00, 0, 0,  1, 0, 4'd2, S_WK, 0, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd2, S_WK, 0, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd2, S_WK, 0, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd2, S_DN, 0, 2'b11, 1, 1, 1, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd2, S_I,  0, 2'b11, 1, 1, 0, 0);
      // mode 10, second request in DRAIN ignored, flush ignored in SLEEP, zero wake delay
      add(1, 2'b10, 0, 0,  0, 0, 4'd0, S_DR, 1, 2'b11, 1, 1, 0, 0);
      add(1, 2'b01, 0, 0,  0, 0, 4'd0, S_DR, 1, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, AK, 0, 0, 4'd0, S_SL, 0, 2'b01, 0, 1, 0, 0);
      add(0, 2'b00, 1, 0,  0, 0, 4'd0, S_SL, 0, 2'b01, 0, 1, 0, 0);
      add(0, 2'b00, 0, 0,  1, 0, 4'd0, S_WK, 0, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd0, S_DN, 0, 2'b11, 1, 1, 1, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd0, S_I,  0, 2'b11, 1, 1, 0, 0);
      // flush together with all acks in DRAIN
      add(1, 2'b01, 0, 0,  0, 0, 4'd0, S_DR, 1, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 1, AK, 0, 0, 4'd0, S_I,  0, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd0, S_I,  0, 2'b11, 1, 1, 0, 0);
      // dbg_wake in SLEEP bypasses a 15-cycle wake delay
      add(1, 2'b01, 0, 0,  0, 0, 4'd15, S_DR, 1, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, AK, 0, 0, 4'd15, S_SL, 0, 2'b10, 0, 1, 0, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd15, S_SL, 0, 2'b10, 0, 1, 0, 0);
      add(0, 2'b00, 0, 0,  0, 1, 4'd15, S_DN, 0, 2'b11, 1, 1, 1, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd15, S_I,  0, 2'b11, 1, 1, 0, 0);
      // illegal mode goes straight to DONE
      add(1, 2'b11, 0, 0,  0, 0, 4'd0, S_DN, 0, 2'b11, 1, 1, 1, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd0, S_I,  0, 2'b11, 1, 1, 0, 0);
      // wake and acks in the same DRAIN cycle: wake wins
      add(1, 2'b10, 0, 0,  0, 0, 4'd3, S_DR, 1, 2'b11, 1, 1, 0, 0);
      add(0, 2'b00, 0, AK, 1, 0, 4'd3, S_DN, 0, 2'b11, 1, 1, 1, 0);
      add(0, 2'b00, 0, 0,  0, 0, 4'd3, S_I,  0, 2'b11, 1, 1, 0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].req, vecs[i].mode, vecs[i].flush, vecs[i].ack, vecs[i].iw, vecs[i].dw, vecs[i].cfg);
         step();
         exp_q.push_back({vecs[i].st, vecs[i].nop, vecs[i].lb, vecs[i].ce, vecs[i].cm, vecs[i].ab});
         act = {seq_state, cp0_xx_no_op_req, lpmd_b, (vecs[i].ce_chk ? cp0_yy_clk_en : vecs[i].ce),
                lpmd_cmplt, lpmd_abort};
         check($sformatf("vec%0d {st,nop,lb,ce,cm,ab}", i), {7'd0, act}, {7'd0, exp_q.pop_front()});
      end

      // drain timeout: abort on the 256th edge after entry
      drain_255("to", 2'b01);
      step();
      check("to_abort",   {15'd0, lpmd_abort}, 16'h1);
      check("to_state",   {13'd0, seq_state}, {13'd0, S_I});
      check("to_lpmd_b",  {14'd0, lpmd_b}, 16'h3);
      check("to_no_op",   {15'd0, cp0_xx_no_op_req}, 16'h0);
      step();
      check("to_abort_1cyc", {15'd0, lpmd_abort}, 16'h0);

      // acks arriving on the timeout edge still win
      drain_255("late", 2'b10);
      drive(1'b0, 2'b00, 1'b0, AK, 1'b0, 1'b0, 4'd0);
      step();
      check("late_state",  {13'd0, seq_state}, {13'd0, S_SL});
      check("late_abort",  {15'd0, lpmd_abort}, 16'h0);
      check("late_lpmd_b", {14'd0, lpmd_b}, 16'h1);
      @(negedge clk);
      drive(1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0);
      @(negedge clk);
      drive(1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0);
      repeat (3) step();
      check("late_back_idle", {13'd0, seq_state}, {13'd0, S_I});

      // reset pulsed in SLEEP restores the clock enable without a clock edge
      @(negedge clk);
      drive(1'b1, 2'b01, 1'b0, 4'h0, 1'b0, 1'b0, 4'd5);
      @(negedge clk);
      drive(1'b0, 2'b00, 1'b0, AK, 1'b0, 1'b0, 4'd5);
      @(negedge clk);
      drive(1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 4'd5);
      step();
      check("rs_sleep_ce", {12'd0, seq_state, cp0_yy_clk_en}, {12'd0, S_SL, 1'b0});
      #2 rst = 1'b1;
      #1;
      check("rs_async_ce",     {15'd0, cp0_yy_clk_en}, 16'h1);
      check("rs_async_state",  {13'd0, seq_state}, {13'd0, S_I});
      check("rs_async_lpmd_b", {14'd0, lpmd_b}, 16'h3);
      cm_seen = 1'b0;
      repeat (2) begin
         step();
         if (lpmd_cmplt !== 1'b0) cm_seen = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         step();
         if (lpmd_cmplt !== 1'b0) cm_seen = 1'b1;
      end
      check("rs_no_cmplt", {15'd0, cm_seen}, 16'h0);
      check("rs_idle",     {13'd0, seq_state}, {13'd0, S_I});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
